// File: rtl/bsg_fma_rr_sched.sv
// ---------------------------------------------------------------------------
// bsg_fma_rr_sched
//   Two requesters share one bsg_fma multiply datapath through a two-stage
//   pipeline. A one-bit round-robin pointer decides which port wins when both
//   request in the same cycle. Each result carries the index of its requester.
//
//   Stage S1 registers the winning operands and tag, and feeds bsg_fma
//   combinationally. Stage S2 registers mul_o and the tag, and drives the
//   output. Both stages use valid/accept flow control, so a full pipeline can
//   drain and refill in the same cycle without a bubble.
//
// Ports
//   clk_i             clock, rising edge
//   reset_i           synchronous active-high reset
//   a0_i, b0_i, v0_i  port-0 operands and request valid
//   ready0_o          port-0 request accepted when high with v0_i
//   a1_i, b1_i, v1_i  port-1 operands and request valid
//   ready1_o          port-1 request accepted when high with v1_i
//   data_o            result (mul_o of the owning request)
//   tag_o             index of the requester that owns data_o
//   v_o               data_o/tag_o valid
//   yumi_i            consumer takes the result this cycle
//   busy_o            either pipeline stage holds a valid entry
//
// bsg_fma (same file)
//   Shared multiply datapath. mul_o is the product a_i * b_i truncated to
//   width_lp bits.
// ---------------------------------------------------------------------------

module bsg_fma #(
   parameter int exp_p = 8,
   parameter int sig_p = 23,
   localparam int width_lp = exp_p + sig_p + 1
) (
   input  logic [width_lp-1:0] a_i,
   input  logic [width_lp-1:0] b_i,
   output logic [width_lp-1:0] mul_o
);

   assign mul_o = a_i * b_i;

endmodule

module bsg_fma_rr_sched #(
   parameter int exp_p = 8,
   parameter int sig_p = 23,
   localparam int width_lp = exp_p + sig_p + 1
) (
   input  logic                clk_i,
   input  logic                reset_i,

   input  logic [width_lp-1:0] a0_i,
   input  logic [width_lp-1:0] b0_i,
   input  logic                v0_i,
   output logic                ready0_o,

   input  logic [width_lp-1:0] a1_i,
   input  logic [width_lp-1:0] b1_i,
   input  logic                v1_i,
   output logic                ready1_o,

   output logic [width_lp-1:0] data_o,
   output logic                tag_o,
   output logic                v_o,
   input  logic                yumi_i,

   output logic                busy_o
);

   // S1: operand register
   logic                s1_v_q,   s1_v_d;
   logic [width_lp-1:0] s1_a_q,   s1_a_d;
   logic [width_lp-1:0] s1_b_q,   s1_b_d;
   logic                s1_tag_q, s1_tag_d;

   // S2: result register
   logic                s2_v_q,    s2_v_d;
   logic [width_lp-1:0] s2_data_q, s2_data_d;
   logic                s2_tag_q,  s2_tag_d;

   // Round-robin pointer: the port that wins a tie
   logic                pri_q, pri_d;

   logic                s2_accepts;
   logic                s1_adv;
   logic                s1_accepts;
   logic                acc0;
   logic                acc1;
   logic [width_lp-1:0] mul_lo;

   bsg_fma #(
      .exp_p (exp_p),
      .sig_p (sig_p)
   ) fma (
      .a_i   (s1_a_q),
      .b_i   (s1_b_q),
      .mul_o (mul_lo)
   );

   always_comb begin
      // yumi_i is only meaningful while S2 holds a result; when S2 is empty
      // it accepts regardless, so a stray yumi_i has no effect.
      s2_accepts = ~s2_v_q | yumi_i;
      s1_adv     = s1_v_q & s2_accepts;
      s1_accepts = ~s1_v_q | s1_adv;

      // Each port is blocked only when the other port requests and owns the
      // tie-break, so the two readies can never both fire with both valids.
      ready0_o = ~reset_i & s1_accepts & (~v1_i | ~pri_q);
      ready1_o = ~reset_i & s1_accepts & (~v0_i |  pri_q);

      acc0 = v0_i & ready0_o;
      acc1 = v1_i & ready1_o;

      s1_v_d    = s1_v_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_tag_d  = s1_tag_q;
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_tag_d  = s2_tag_q;
      pri_d     = pri_q;

      if (s2_accepts) begin
         s2_v_d = s1_v_q;
         if (s1_v_q) begin
            s2_data_d = mul_lo;
            s2_tag_d  = s1_tag_q;
         end
      end

      if (s1_accepts) begin
         s1_v_d = acc0 | acc1;
         if (acc0) begin
            s1_a_d   = a0_i;
            s1_b_d   = b0_i;
            s1_tag_d = 1'b0;
            pri_d    = 1'b1;
         end else if (acc1) begin
            s1_a_d   = a1_i;
            s1_b_d   = b1_i;
            s1_tag_d = 1'b1;
            pri_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_v_q    <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_tag_q  <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_tag_q  <= 1'b0;
         pri_q     <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_tag_q  <= s1_tag_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_tag_q  <= s2_tag_d;
         pri_q     <= pri_d;
      end
   end

   assign data_o = s2_data_q;
   assign tag_o  = s2_tag_q;
   assign v_o    = s2_v_q;
   assign busy_o = s1_v_q | s2_v_q;

endmodule

// File: doc/bsg_fma_rr_sched.md
BSG_FMA_RR_SCHED -- requirements
Module: bsg_fma_rr_sched

Interface
REQ-001 SHALL have parameter exp_p, default 8, meaning exponent field width.
REQ-002 SHALL have parameter sig_p, default 23, meaning significand field width.
REQ-003 SHALL derive localparam width_lp = exp_p + sig_p + 1, meaning operand and result width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports a0_i, b0_i  input  width_lp each  port-0 operands.
REQ-007 SHALL have port v0_i  input  1  port-0 request valid.
REQ-008 SHALL have port ready0_o  output  1  port-0 request accepted this cycle when high with v0_i.
REQ-009 SHALL have ports a1_i, b1_i, v1_i, ready1_o, identical to REQ-006..008, for port 1.
REQ-010 SHALL have port data_o  output  width_lp  result.
REQ-011 SHALL have port tag_o  output  1  index of the requester that owns data_o.
REQ-012 SHALL have port v_o  output  1  data_o/tag_o valid.
REQ-013 SHALL have port yumi_i  input  1  consumer takes the result this cycle; legal only while v_o = 1.
REQ-014 SHALL have port busy_o  output  1  high when either pipeline stage holds a valid entry.

Function
REQ-015 SHALL contain one shared bsg_fma instance, with the same exp_p/sig_p, as its only multiply datapath.
REQ-016 SHALL have stage S1 (operand register: a, b, tag, valid) feeding bsg_fma combinationally.
REQ-017 SHALL have stage S2 (result register: mul_o, tag, valid), driving data_o, tag_o, v_o.
REQ-018 SHALL drain S2 when v_o & yumi_i; S2 accepts when it is empty or draining.
REQ-019 SHALL advance S1 into S2 when S1 is valid and S2 accepts; S1 accepts when it is empty or advancing.
REQ-020 SHALL keep a one-bit priority pointer pri; port pri wins when v0_i and v1_i are both high.
REQ-021 SHALL compute ready0_o = S1_accepts & (~v1_i | pri==0), and ready1_o = S1_accepts & (~v0_i | pri==1).
REQ-022 SHALL never assert ready0_o and ready1_o with both of the matching valids high.
REQ-023 SHALL accept a request when v_k_i & ready_k_o, capturing a_k_i, b_k_i and tag k into S1.
REQ-024 SHALL set pri to the other port (~k) on each accepted request; with no accept, pri holds.
REQ-025 SHALL set latency so a request accepted at edge N shows v_o = 1 after edge N+1, with no stall.
REQ-026 SHALL sustain a throughput of one request per cycle while yumi_i is held high.
REQ-027 SHALL hold a stalled S2 (v_o & ~yumi_i): data_o and tag_o stable, S1 frozen, and once S1 is full ready0_o = ready1_o = 0.
REQ-028 SHALL, on simultaneous drain and refill of S2 (or S1) in one cycle, load the new entry with no bubble.
REQ-029 SHALL ignore yumi_i while v_o = 0, with no state change.
REQ-030 SHALL accept a request with v_k_i deasserted after acceptance normally; the scheduler never references it again.
REQ-031 SHALL compute busy_o = S1_valid | S2_valid.

Reset
REQ-032 SHALL, while reset_i = 1 at an edge, clear S1_valid and S2_valid, set pri = 0, and zero data_o and tag_o.
REQ-033 SHALL hold ready0_o = ready1_o = 0 during any cycle with reset_i = 1.
REQ-034 SHALL discard in-flight entries on reset mid-operation, without producing their results.
REQ-035 SHALL present v_o = 0 and busy_o = 0 in the first cycle after reset deasserts.

Verification
REQ-036 SHALL cover single request: v0_i=1, a0=3, b0=5 at edge N -> v_o=1, data_o=15, tag_o=0 after edge N+1; yumi_i -> v_o=0.
REQ-037 SHALL cover contention after reset: v0=v1=1 held, yumi_i=1 -> grants 0,1,0,1; tag_o stream 0,1,0,1, one result per cycle.
REQ-038 SHALL cover stall: yumi_i=0 with both valids high -> exactly 2 accepts, then ready0/1=0; data_o held; raising yumi_i resumes 1/cycle.
REQ-039 SHALL cover reset mid-flight: two accepted requests, reset_i=1 one cycle -> v_o=0, busy_o=0, pri=0; no stale result appears.
REQ-040 SHALL cover random stimulus: random valids, operands and yumi_i over 10k cycles -> every data_o equals a scoreboard bsg_fma mul_o, order is preserved, and tags match.
